// File: rtl/fe_fifo_packer.sv
// fe_fifo_packer: buffers capture-FIFO entries {cmd, time, data} and serialises each into 2-4 bytes.
// Latency: a write into an empty buffer with the serializer idle gives a valid header byte two cycles later.
// Backpressure: O_byte/O_byte_valid are registered and hold until I_byte_ready; a write to a full buffer is dropped and flagged.
//
// Ports:
//   fe_clk, reset_i                       clock, synchronous active-high reset
//   I_fifo_wr/_command/_time/_data        entry write strobe and fields
//   O_byte, O_byte_valid, I_byte_ready    serialised byte stream (valid/ready)
//   O_overflow, I_clear_overflow          sticky drop flag and its clear
//   O_level, O_idle                       buffer occupancy, fully-idle indication
module fe_fifo_packer #(
    parameter int         pDEPTH       = 16,
    parameter int         pSHORT_WIDTH = 3,
    parameter logic [1:0] pCMD_TIME    = 2'd2
) (
    input  logic                      fe_clk,
    input  logic                      reset_i,
    input  logic                      I_fifo_wr,
    input  logic [1:0]                I_fifo_command,
    input  logic [15:0]               I_fifo_time,
    input  logic [7:0]                I_fifo_data,
    output logic [7:0]                O_byte,
    output logic                      O_byte_valid,
    input  logic                      I_byte_ready,
    output logic                      O_overflow,
    input  logic                      I_clear_overflow,
    output logic [$clog2(pDEPTH):0]   O_level,
    output logic                      O_idle
);

    localparam int AW = $clog2(pDEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [1:0]  cmd;
        logic [15:0] ts;
        logic [7:0]  dat;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_TS_HI,
        S_TS_LO,
        S_DATA
    } state_t;

    entry_t          mem_q [pDEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            ovf_q, ovf_d;
    state_t          state_q, state_d;
    entry_t          ent_q, ent_d;
    logic [7:0]      byte_q, byte_d;
    logic            vld_q, vld_d;

    logic            full;
    logic            empty;
    logic            wr_acc;
    logic            drop;
    logic            pop;
    logic            hs;
    logic            ent_done;
    entry_t          head;
    entry_t          wr_ent;

    // Long when the entry is timestamp-only or the time does not fit the short field.
    function automatic logic is_long(input entry_t e);
        return (e.cmd == pCMD_TIME) || ((e.ts >> pSHORT_WIDTH) != 16'd0);
    endfunction

    // Header byte: {cmd, short time or 0, long flag, 2'b00}; the short field is 3 bits wide.
    function automatic logic [7:0] hdr_of(input entry_t e);
        logic lng;
        lng = is_long(e);
        return {e.cmd, (lng ? 3'b000 : e.ts[2:0]), lng, 2'b00};
    endfunction

    assign full   = (level_q == LW'(pDEPTH));
    assign empty  = (level_q == '0);
    // Fullness is judged at the start of the cycle, so a same-cycle pop does not rescue a write.
    assign wr_acc = I_fifo_wr & ~full;
    assign drop   = I_fifo_wr & full;
    assign head   = mem_q[rd_ptr_q];
    assign hs     = vld_q & I_byte_ready;
    assign wr_ent = '{cmd: I_fifo_command, ts: I_fifo_time, dat: I_fifo_data};

    // Serializer next state and registered byte output.
    always_comb begin
        state_d  = state_q;
        ent_d    = ent_q;
        byte_d   = byte_q;
        vld_d    = vld_q;
        pop      = 1'b0;
        ent_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                vld_d = 1'b0;
                if (!empty) begin
                    pop = 1'b1;
                end
            end
            S_HDR: begin
                if (hs) begin
                    if (is_long(ent_q)) begin
                        state_d = S_TS_HI;
                        byte_d  = ent_q.ts[15:8];
                    end else begin
                        state_d = S_DATA;
                        byte_d  = ent_q.dat;
                    end
                end
            end
            S_TS_HI: begin
                if (hs) begin
                    state_d = S_TS_LO;
                    byte_d  = ent_q.ts[7:0];
                end
            end
            S_TS_LO: begin
                if (hs) begin
                    if (ent_q.cmd != pCMD_TIME) begin
                        state_d = S_DATA;
                        byte_d  = ent_q.dat;
                    end else begin
                        ent_done = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (hs) begin
                    ent_done = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                vld_d   = 1'b0;
            end
        endcase

        // Chain straight into the next entry so back-to-back entries leave no bubble.
        if (ent_done) begin
            if (!empty) begin
                pop = 1'b1;
            end else begin
                state_d = S_IDLE;
                vld_d   = 1'b0;
            end
        end

        if (pop) begin
            ent_d   = head;
            state_d = S_HDR;
            byte_d  = hdr_of(head);
            vld_d   = 1'b1;
        end
    end

    // Buffer bookkeeping.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(wr_acc);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + LW'(wr_acc) - LW'(pop);
        // A drop in the same cycle as a clear keeps the flag set.
        ovf_d    = drop | (ovf_q & ~I_clear_overflow);
    end

    always_ff @(posedge fe_clk) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            state_q  <= S_IDLE;
            ent_q    <= '0;
            byte_q   <= 8'd0;
            vld_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            ent_q    <= ent_d;
            byte_q   <= byte_d;
            vld_q    <= vld_d;
        end
    end

    // Entry storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge fe_clk) begin
        if (wr_acc && !reset_i) begin
            mem_q[wr_ptr_q] <= wr_ent;
        end
    end

    assign O_byte       = byte_q;
    assign O_byte_valid = vld_q;
    assign O_overflow   = ovf_q;
    assign O_level      = level_q;
    assign O_idle       = empty && (state_q == S_IDLE) && !vld_q;

endmodule

// File: tb/tb_fe_fifo_packer.sv
// tb_fe_fifo_packer: directed stimulus with a byte scoreboard for fe_fifo_packer.
// Latency: stimulus pushes expected bytes; a negedge monitor pops on every handshake.
// Backpressure: the monitor also requires O_byte to hold while stalled.
module tb_fe_fifo_packer;

    localparam int DEPTH = 16;

    logic        fe_clk = 1'b0;
    logic        reset_i;
    logic        I_fifo_wr;
    logic [1:0]  I_fifo_command;
    logic [15:0] I_fifo_time;
    logic [7:0]  I_fifo_data;
    logic [7:0]  O_byte;
    logic        O_byte_valid;
    logic        I_byte_ready;
    logic        O_overflow;
    logic        I_clear_overflow;
    logic [4:0]  O_level;
    logic        O_idle;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];
    logic        stall_prev = 1'b0;
    logic [7:0]  prev_byte  = 8'd0;

    fe_fifo_packer #(.pDEPTH(DEPTH), .pSHORT_WIDTH(3), .pCMD_TIME(2'd2)) dut (
        .fe_clk           (fe_clk),
        .reset_i          (reset_i),
        .I_fifo_wr        (I_fifo_wr),
        .I_fifo_command   (I_fifo_command),
        .I_fifo_time      (I_fifo_time),
        .I_fifo_data      (I_fifo_data),
        .O_byte           (O_byte),
        .O_byte_valid     (O_byte_valid),
        .I_byte_ready     (I_byte_ready),
        .O_overflow       (O_overflow),
        .I_clear_overflow (I_clear_overflow),
        .O_level          (O_level),
        .O_idle           (O_idle)
    );

    always #5 fe_clk = ~fe_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a handshake happens at the next posedge when valid & ready at the negedge.
    always @(negedge fe_clk) begin
        logic [7:0] e;
        if (stall_prev && reset_i !== 1'b1) begin
            n_chk++;
            if (O_byte_valid !== 1'b1 || O_byte !== prev_byte) begin
                n_fail++;
                $display("FAIL stall_hold: got vld=%b byte=%0h expected vld=1 byte=%0h",
                         O_byte_valid, O_byte, prev_byte);
            end
        end
        if (O_byte_valid === 1'b1 && I_byte_ready === 1'b1) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_byte: got %0h expected no byte", O_byte);
            end else begin
                e = exp_q.pop_front();
                if (O_byte !== e) begin
                    n_fail++;
                    $display("FAIL byte: got %0h expected %0h", O_byte, e);
                end
            end
        end
        stall_prev = (O_byte_valid === 1'b1) && (I_byte_ready === 1'b0);
        prev_byte  = O_byte;
    end

    task automatic sync();
        @(posedge fe_clk);
        #1;
    endtask

    // Called at posedge+1; drives one write for one cycle and returns at the next posedge+1.
    task automatic wr(input logic [1:0] c, input logic [15:0] t, input logic [7:0] d);
        I_fifo_wr      = 1'b1;
        I_fifo_command = c;
        I_fifo_time    = t;
        I_fifo_data    = d;
        sync();
        I_fifo_wr      = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge fe_clk);
            if (O_idle === 1'b1 && exp_q.size() == 0) done = 1'b1;
        end
        chk({name, "_drain"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i          = 1'b1;
        I_fifo_wr        = 1'b0;
        I_fifo_command   = 2'd0;
        I_fifo_time      = 16'd0;
        I_fifo_data      = 8'd0;
        I_byte_ready     = 1'b0;
        I_clear_overflow = 1'b0;
        repeat (3) @(posedge fe_clk);
        @(negedge fe_clk);
        chk("rst_byte",  {24'd0, O_byte}, 32'h00);
        chk("rst_vld",   {31'd0, O_byte_valid}, 32'd0);
        chk("rst_ovf",   {31'd0, O_overflow}, 32'd0);
        chk("rst_level", {27'd0, O_level}, 32'd0);
        chk("rst_idle",  {31'd0, O_idle}, 32'd1);
        sync();
        reset_i      = 1'b0;
        I_byte_ready = 1'b1;

        // Single short entry with latency check.
        sync();
        exp_q.push_back(8'h28); exp_q.push_back(8'hA5);
        wr(2'd0, 16'd5, 8'hA5);
        @(negedge fe_clk);
        chk("lat_level_n1", {27'd0, O_level}, 32'd1);
        chk("lat_vld_n1",   {31'd0, O_byte_valid}, 32'd0);
        @(negedge fe_clk);
        chk("lat_vld_n2",   {31'd0, O_byte_valid}, 32'd1);
        chk("lat_hdr_n2",   {24'd0, O_byte}, 32'h28);
        chk("lat_level_n2", {27'd0, O_level}, 32'd0);
        wait_idle("short");
        chk("short_idle", {31'd0, O_idle}, 32'd1);

        // Long data entry at time=8, then time=7 short boundary.
        sync();
        exp_q.push_back(8'h44); exp_q.push_back(8'h00); exp_q.push_back(8'h08); exp_q.push_back(8'h3C);
        wr(2'd1, 16'h0008, 8'h3C);
        wait_idle("long8");
        sync();
        exp_q.push_back(8'h78); exp_q.push_back(8'h11);
        wr(2'd1, 16'h0007, 8'h11);
        wait_idle("short7");

        // Timestamp-only entries, including a small time that is still long.
        sync();
        exp_q.push_back(8'h84); exp_q.push_back(8'h12); exp_q.push_back(8'h34);
        wr(2'd2, 16'h1234, 8'hEE);
        exp_q.push_back(8'h84); exp_q.push_back(8'h00); exp_q.push_back(8'h03);
        wr(2'd2, 16'h0003, 8'hEE);
        // 0xFFFF timestamp.
        exp_q.push_back(8'hC4); exp_q.push_back(8'hFF); exp_q.push_back(8'hFF); exp_q.push_back(8'h09);
        wr(2'd3, 16'hFFFF, 8'h09);
        wait_idle("time_ffff");

        // Back-pressure: three short entries, stall 10 cycles.
        sync();
        I_byte_ready = 1'b0;
        exp_q.push_back(8'h08); exp_q.push_back(8'h01);
        wr(2'd0, 16'd1, 8'h01);
        exp_q.push_back(8'h50); exp_q.push_back(8'h02);
        wr(2'd1, 16'd2, 8'h02);
        exp_q.push_back(8'hF0); exp_q.push_back(8'h03);
        wr(2'd3, 16'd6, 8'h03);
        for (int i = 0; i < 10; i++) begin
            @(negedge fe_clk);
            chk("bp_level", {27'd0, O_level}, 32'd2);
        end
        sync();
        I_byte_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge fe_clk);
            chk("bp_gapless", {31'd0, O_byte_valid}, 32'd1);
        end
        wait_idle("bp");

        // Overflow: one entry latched by the serializer, DEPTH buffered, last dropped.
        sync();
        I_byte_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            logic [15:0] t;
            logic [7:0]  d;
            logic [7:0]  h;
            t = 16'(i % 8);
            d = 8'(i);
            h = {2'b00, t[2:0], 3'b000};
            if (i < DEPTH + 1) begin
                exp_q.push_back(h);
                exp_q.push_back(d);
            end
            if (i == DEPTH + 1) begin
                chk("ovf_before_drop", {31'd0, O_overflow}, 32'd0);
                chk("ovf_full_level",  {27'd0, O_level}, 32'(DEPTH));
            end
            wr(2'd0, t, d);
        end
        @(negedge fe_clk);
        chk("ovf_level", {27'd0, O_level}, 32'(DEPTH));
        chk("ovf_flag",  {31'd0, O_overflow}, 32'd1);
        sync();
        I_clear_overflow = 1'b1;
        sync();
        I_clear_overflow = 1'b0;
        @(negedge fe_clk);
        chk("ovf_cleared", {31'd0, O_overflow}, 32'd0);
        // Drop and clear in the same cycle: the drop wins.
        sync();
        I_clear_overflow = 1'b1;
        wr(2'd0, 16'd1, 8'hEE);
        I_clear_overflow = 1'b0;
        @(negedge fe_clk);
        chk("ovf_drop_wins", {31'd0, O_overflow}, 32'd1);
        sync();
        I_clear_overflow = 1'b1;
        sync();
        I_clear_overflow = 1'b0;
        I_byte_ready     = 1'b1;
        @(negedge fe_clk);
        chk("ovf_cleared2", {31'd0, O_overflow}, 32'd0);
        wait_idle("ovf");

        // Reset after TS_HI of a long entry was accepted.
        sync();
        exp_q.push_back(8'h44); exp_q.push_back(8'h12);
        wr(2'd1, 16'h1234, 8'h55);
        @(posedge fe_clk);
        @(posedge fe_clk);
        @(posedge fe_clk);
        #1;
        I_byte_ready = 1'b0;
        reset_i      = 1'b1;
        @(negedge fe_clk);
        chk("mid_ts_lo", {23'd0, O_byte_valid, O_byte}, {23'd0, 1'b1, 8'h34});
        @(negedge fe_clk);
        chk("mid_rst_vld",   {31'd0, O_byte_valid}, 32'd0);
        chk("mid_rst_level", {27'd0, O_level}, 32'd0);
        chk("mid_rst_idle",  {31'd0, O_idle}, 32'd1);
        sync();
        reset_i      = 1'b0;
        I_byte_ready = 1'b1;
        repeat (10) @(negedge fe_clk);
        chk("mid_rst_quiet", {31'd0, O_byte_valid}, 32'd0);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
